// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_t : CLEAR (post-reset zeroing sweep) / RUN (normal traffic)
//   pack_idx   : base bit of slice i in a bus packed with w-bit slices
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

   function automatic int unsigned pack_idx(input int unsigned i, input int unsigned w);
      return i * w;
   endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file.
//   ready_i   : file is out of the clear sweep; outputs forced to 0 when low
//   ra_i      : read address
//   we_i/wa_i/wd_i : all write ports of the current cycle, for bypass
//   rf_data_i : stored word at ra_i
//   pend_i    : stored pending bit at ra_i
//   rd_c_o    : read data (bypassed, zero-forced), combinational
//   pend_c_o  : pending flag consistent with rd_c_o, combinational
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned NWRITE   = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter int unsigned AW       = 5
) (
   input  logic                    ready_i,
   input  logic [AW-1:0]           ra_i,
   input  logic [NWRITE-1:0]       we_i,
   input  logic [NWRITE*AW-1:0]    wa_i,
   input  logic [NWRITE*WIDTH-1:0] wd_i,
   input  logic [WIDTH-1:0]        rf_data_i,
   input  logic                    pend_i,
   output logic [WIDTH-1:0]        rd_c_o,
   output logic                    pend_c_o
);

   // Later ports overwrite earlier matches, so the highest index wins.
   // A matching write retires the producer, so pend is cleared with the bypass.
   always_comb begin
      rd_c_o   = rf_data_i;
      pend_c_o = pend_i;
      for (int unsigned i = 0; i < NWRITE; i++) begin
         if (we_i[i] && (wa_i[pack_idx(i, AW) +: AW] == ra_i)) begin
            rd_c_o   = wd_i[pack_idx(i, WIDTH) +: WIDTH];
            pend_c_o = 1'b0;
         end
      end
      if (ZERO_REG && (ra_i == '0)) begin
         rd_c_o   = '0;
         pend_c_o = 1'b0;
      end
      if (!ready_i) begin
         rd_c_o   = '0;
         pend_c_o = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write bypass, optional
// hardwired-zero register 0, post-reset clear sweep and pending scoreboard.
//   clk, reset     : clock, synchronous active-high reset
//   ready          : sweep done, file accepts traffic (registered)
//   we/wa/wd       : NWRITE write ports, higher index has priority
//   ra/rd/pend     : NREAD read ports, rd/pend combinational
//   resv_en/resv_a : reserve a destination (set its pending bit)
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned NWRITE   = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    ready,
   input  logic [NWRITE-1:0]       we,
   input  logic [NWRITE*AW-1:0]    wa,
   input  logic [NWRITE*WIDTH-1:0] wd,
   input  logic [NREAD*AW-1:0]     ra,
   output logic [NREAD*WIDTH-1:0]  rd,
   output logic [NREAD-1:0]        pend,
   input  logic                    resv_en,
   input  logic [AW-1:0]           resv_a
);

   rf_state_t        state_q, state_d;
   logic [AW-1:0]    clr_idx_q, clr_idx_d;
   logic             ready_q, ready_d;
   logic [DEPTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] rf_q [DEPTH];
   logic [WIDTH-1:0] rf_d [DEPTH];

   // Control state and scoreboard.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         pend_q    <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         pend_q    <= pend_d;
         ready_q   <= ready_d;
      end
   end

   // Storage; zeroed by the sweep rather than by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rf_q <= rf_d;
      end
   end

   // Next state: sweep in CLEAR, writes and reservations in RUN.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      pend_d    = pend_q;
      rf_d      = rf_q;
      unique case (state_q)
         CLEAR: begin
            rf_d[clr_idx_q]   = '0;
            pend_d[clr_idx_q] = 1'b0;
            clr_idx_d         = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(DEPTH - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            for (int unsigned i = 0; i < NWRITE; i++) begin
               if (we[i] && !(ZERO_REG && (wa[pack_idx(i, AW) +: AW] == '0))) begin
                  rf_d[wa[pack_idx(i, AW) +: AW]]   = wd[pack_idx(i, WIDTH) +: WIDTH];
                  pend_d[wa[pack_idx(i, AW) +: AW]] = 1'b0;
               end
            end
            // Applied after the write clears: a same-edge reservation wins.
            if (resv_en && !(ZERO_REG && (resv_a == '0))) begin
               pend_d[resv_a] = 1'b1;
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
      ready_d = (state_d == RUN);
   end

   assign ready = ready_q;

   for (genvar j = 0; j < NREAD; j++) begin : g_rd
      logic [AW-1:0] ra_j;
      assign ra_j = ra[pack_idx(j, AW) +: AW];

      regfile_rdport #(
         .WIDTH    (WIDTH),
         .NWRITE   (NWRITE),
         .ZERO_REG (ZERO_REG),
         .AW       (AW)
      ) u_rdport (
         .ready_i   (ready_q),
         .ra_i      (ra_j),
         .we_i      (we),
         .wa_i      (wa),
         .wd_i      (wd),
         .rf_data_i (rf_q[ra_j]),
         .pend_i    (pend_q[ra_j]),
         .rd_c_o    (rd[pack_idx(j, WIDTH) +: WIDTH]),
         .pend_c_o  (pend[j])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a 32x32 2R/2W instance checked every
// cycle against a behavioural model, plus a 16-bit 8-deep 3R/1W instance.
module tb_regfile_mp;

   logic clk;

   // Default configuration instance.
   logic        reset0, ready0, resv_en0;
   logic [1:0]  we0, pend0;
   logic [9:0]  wa0, ra0;
   logic [63:0] wd0, rd0;
   logic [4:0]  resv_a0;

   // Small configuration instance.
   logic        reset1, ready1, resv_en1;
   logic [0:0]  we1;
   logic [2:0]  wa1, pend1, resv_a1;
   logic [15:0] wd1;
   logic [8:0]  ra1;
   logic [47:0] rd1;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_mp u_dut0 (
      .clk(clk), .reset(reset0), .ready(ready0), .we(we0), .wa(wa0), .wd(wd0),
      .ra(ra0), .rd(rd0), .pend(pend0), .resv_en(resv_en0), .resv_a(resv_a0)
   );

   regfile_mp #(.WIDTH(16), .DEPTH(8), .NREAD(3), .NWRITE(1)) u_dut1 (
      .clk(clk), .reset(reset1), .ready(ready1), .we(we1), .wa(wa1), .wd(wd1),
      .ra(ra1), .rd(rd1), .pend(pend1), .resv_en(resv_en1), .resv_a(resv_a1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of the default instance.
   bit          m_valid = 1'b0;
   int          m_cnt = 0;
   logic [31:0] m_mem [32];
   bit          m_pend [32];

   always @(posedge clk) begin
      if (reset0) begin
         m_valid = 1'b1;
         m_cnt   = 0;
         for (int r = 0; r < 32; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
         end
      end else if (m_valid) begin
         if (m_cnt < 32) begin
            m_cnt++;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (we0[i] && wa0[i*5 +: 5] != 0) begin
                  m_mem[wa0[i*5 +: 5]]  = wd0[i*32 +: 32];
                  m_pend[wa0[i*5 +: 5]] = 1'b0;
               end
            end
            if (resv_en0 && resv_a0 != 0) m_pend[resv_a0] = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      int          a;
      logic [31:0] er;
      logic        ep;
      if (m_valid) begin
         chk("ready", ready0, m_cnt == 32);
         for (int j = 0; j < 2; j++) begin
            a  = ra0[j*5 +: 5];
            er = '0;
            ep = 1'b0;
            if (m_cnt == 32 && a != 0) begin
               er = m_mem[a];
               ep = m_pend[a];
               for (int i = 0; i < 2; i++) begin
                  if (we0[i] && wa0[i*5 +: 5] == a) begin
                     er = wd0[i*32 +: 32];
                     ep = 1'b0;
                  end
               end
            end
            chk($sformatf("model_rd%0d", j), rd0[j*32 +: 32], er);
            chk($sformatf("model_pend%0d", j), pend0[j], ep);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      we0 = '0;
      resv_en0 = 1'b0;
   endtask

   function automatic logic [4:0] addr5();
      if ($urandom_range(0, 3) == 0) return 5'($urandom);
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      reset0 = 1'b1; we0 = '0; wa0 = '0; wd0 = '0; ra0 = '0; resv_en0 = 1'b0; resv_a0 = '0;
      reset1 = 1'b1; we1 = '0; wa1 = '0; wd1 = '0; ra1 = '0; resv_en1 = 1'b0; resv_a1 = '0;
      tick();
      tick();
      @(negedge clk);
      chk("reset_ready", ready0, 1'b0);
      reset0 = 1'b0;

      // Clear sweep: traffic is ignored, ready rises on the 32nd edge.
      for (int k = 1; k <= 32; k++) begin
         we0 = 2'($urandom); wa0 = 10'($urandom); wd0 = {$urandom, $urandom};
         ra0 = 10'($urandom); resv_en0 = 1'b1; resv_a0 = 5'($urandom);
         tick();
         @(negedge clk);
         chk("sweep_ready", ready0, (k == 32));
         if (k < 32) chk("sweep_rd", rd0, 64'h0);
      end
      idle0();
      for (int r = 0; r < 32; r++) begin
         ra0 = {5'(r), 5'(31 - r)};
         @(negedge clk);
         chk("cleared_rd", rd0, 64'h0);
         chk("cleared_pend", pend0, 2'b00);
         tick();
      end

      // Bypass and persistence.
      we0 = 2'b01; wa0 = {5'd0, 5'd5}; wd0 = {32'h0, 32'hDEADBEEF}; ra0 = {5'd0, 5'd5};
      @(negedge clk);
      chk("bypass_r5", rd0[31:0], 32'hDEADBEEF);
      tick();
      idle0();
      @(negedge clk);
      chk("stored_r5", rd0[31:0], 32'hDEADBEEF);
      tick();

      // Same-address write priority and the zero register.
      we0 = 2'b11; wa0 = {5'd7, 5'd7}; wd0 = {32'h22222222, 32'h11111111}; ra0 = {5'd7, 5'd7};
      @(negedge clk);
      chk("prio_bypass", rd0, 64'h22222222_22222222);
      tick();
      idle0();
      @(negedge clk);
      chk("prio_stored", rd0[31:0], 32'h22222222);
      tick();
      we0 = 2'b01; wa0 = {5'd0, 5'd0}; wd0 = {32'h0, 32'h5}; ra0 = {5'd0, 5'd0};
      @(negedge clk);
      chk("r0_bypass", rd0[31:0], 32'h0);
      tick();
      idle0();
      @(negedge clk);
      chk("r0_stored", rd0[31:0], 32'h0);
      tick();

      // Scoreboard.
      resv_en0 = 1'b1; resv_a0 = 5'd9; ra0 = {5'd9, 5'd0};
      tick();
      idle0();
      @(negedge clk);
      chk("resv_pend", pend0[1], 1'b1);
      tick();
      we0 = 2'b01; wa0 = {5'd0, 5'd9}; wd0 = {32'h0, 32'h99};
      @(negedge clk);
      chk("wr_pend_bypass", pend0[1], 1'b0);
      chk("wr_rd_bypass", rd0[63:32], 32'h99);
      tick();
      idle0();
      @(negedge clk);
      chk("wr_pend_stored", pend0[1], 1'b0);
      tick();
      resv_en0 = 1'b1; resv_a0 = 5'd9; we0 = 2'b01; wa0 = {5'd0, 5'd9}; wd0 = {32'h0, 32'h77};
      tick();
      idle0();
      @(negedge clk);
      chk("resv_wins", pend0[1], 1'b1);
      chk("resv_wins_rd", rd0[63:32], 32'h77);
      tick();

      // Reset mid-RUN restarts the sweep.
      we0 = 2'b01; wa0 = {5'd0, 5'd3}; wd0 = {32'h0, 32'hA5A5A5A5}; ra0 = {5'd9, 5'd3};
      tick();
      idle0();
      @(negedge clk);
      chk("pre_reset_r3", rd0[31:0], 32'hA5A5A5A5);
      chk("pre_reset_pend9", pend0[1], 1'b1);
      reset0 = 1'b1;
      tick();
      reset0 = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", ready0, 1'b0);
      chk("post_reset_rd", rd0, 64'h0);
      chk("post_reset_pend", pend0, 2'b00);
      for (int k = 1; k <= 32; k++) begin
         tick();
         @(negedge clk);
         chk("resweep_ready", ready0, (k == 32));
      end
      chk("resweep_r3", rd0[31:0], 32'h0);
      chk("resweep_pend9", pend0[1], 1'b0);
      tick();

      // Randomised traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         reset0   = ($urandom_range(0, 399) == 0);
         we0      = 2'($urandom);
         wa0      = {addr5(), addr5()};
         wd0      = {$urandom, $urandom};
         ra0      = {addr5(), addr5()};
         resv_en0 = ($urandom_range(0, 3) == 0);
         resv_a0  = addr5();
         tick();
      end
      reset0 = 1'b0;
      idle0();

      // Small configuration: 8-deep sweep and three parallel 16-bit reads.
      reset1 = 1'b0;
      ra1 = {3'd6, 3'd2, 3'd1};
      for (int k = 1; k <= 8; k++) begin
         we1 = 1'b1; wa1 = 3'd1; wd1 = 16'hFFFF;
         tick();
         @(negedge clk);
         chk("small_ready", ready1, (k == 8));
      end
      we1 = 1'b0;
      @(negedge clk);
      chk("small_cleared", rd1, 48'h0);
      tick();
      we1 = 1'b1; wa1 = 3'd1; wd1 = 16'h1111;
      tick();
      wa1 = 3'd2; wd1 = 16'h2222;
      tick();
      wa1 = 3'd6; wd1 = 16'hBEEF;
      tick();
      we1 = 1'b0;
      @(negedge clk);
      chk("small_rd0", rd1[15:0], 16'h1111);
      chk("small_rd1", rd1[31:16], 16'h2222);
      chk("small_rd2", rd1[47:32], 16'hBEEF);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the fixed 32x32 two-read/one-write regfile used in the core datapath. It adds configurable width, depth, read-port count and write-port count. It keeps register 0 hardwired to zero and bypasses same-cycle writes to the read ports. It also adds a sequential post-reset clear sweep and a per-register pending (scoreboard) bit for hazard detection by the decode stage.

Parameters:
WIDTH, 32, data bits per register
DEPTH, 32, number of registers; power of two, at least 2
NREAD, 2, read ports
NWRITE, 2, write ports; higher index has priority
ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and never goes pending
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
ready  out  1  high when the clear sweep is done and the file accepts traffic
we  in  NWRITE  per-port write enable
wa  in  NWRITE*AW  write addresses, port i at bits [i*AW +: AW]
wd  in  NWRITE*WIDTH  write data, port i at bits [i*WIDTH +: WIDTH]
ra  in  NREAD*AW  read addresses, packed the same way
rd  out  NREAD*WIDTH  read data, combinational
pend  out  NREAD  pending flag of the register addressed by each read port
resv_en  in  1  reserve a destination register (set its pending bit)
resv_a  in  AW  address to reserve

Behaviour:
- Synchronous reset and active-high; the clock is clk, the reset is reset. Both are fixed.
- FSM states (regfile_pkg::rf_state_t): CLEAR, RUN.
- Any rising edge with reset=1 gives: state=CLEAR, clr_idx=0, all pending bits=0, ready=0.
- CLEAR, on each edge with reset=0:
  - rf[clr_idx] <= 0 and clr_idx increments.
  - When clr_idx==DEPTH-1, the next state is RUN.
  - ready rises exactly DEPTH edges after reset is released.
  - we and resv_en are ignored.
  - All rd outputs are forced to 0 and all pend outputs to 0.
- reset asserted during CLEAR or RUN restarts the sweep from index 0. Holding reset keeps clr_idx at 0.
- RUN, writes:
  - On each edge, every port with we[i]=1 writes wd[i] to rf[wa[i]].
  - Writes to address 0 are dropped when ZERO_REG=1.
  - If several enabled ports target the same address, the highest port index wins.
- RUN, reads (zero cycles of latency):
  - rd[j] = 0 if ZERO_REG=1 and ra[j]==0.
  - Otherwise rd[j] = wd of the highest-index enabled write port whose wa equals ra[j] (bypass).
  - Otherwise rd[j] = rf[ra[j]].
- Pending bits (DEPTH flops):
  - resv_en sets pend_q[resv_a].
  - Any enabled write to an address clears pend_q at that address.
  - A reserve and a write to the same address on the same edge leave the bit set: the reservation wins, because the write retires an older producer.
  - Address 0 never becomes pending when ZERO_REG=1.
- pend[j] = pend_q[ra[j]] AND NOT (some enabled write port targets ra[j]). The pending flag is consistent with the bypassed data.
- No X propagation: every flop is written during the CLEAR sweep before ready is asserted.

Decomposition:
- Package regfile_pkg holds rf_state_t {CLEAR, RUN} and a function pack_idx(i, w) for the slice base i*w.
- Sub-module regfile_rdport, instantiated NREAD times, does the combinational per-read-port bypass and priority mux, the zero-register force and the pend gating. The parent holds the storage, the FSM and the scoreboard.

Test Plan:
- Reset released at cycle 0, DEPTH=32 -> ready=0 for 32 edges and 1 after the 32nd; every register reads 0; any we/resv_en during CLEAR leaves contents and pend unchanged.
- RUN: port0 writes 0xDEADBEEF to r5, ra0=5 in the same cycle -> rd0=0xDEADBEEF combinationally; the next cycle with we=0 still reads 0xDEADBEEF.
- Port0 writes 0x11111111 and port1 writes 0x22222222 to r7 on the same edge -> bypass and stored value are both 0x22222222; a write of 0x5 to r0 -> r0 reads 0.
- resv_a=9 -> pend=1 on a port reading r9; a write to r9 the next cycle -> pend=0 in that cycle (bypass) and stays 0; reserve plus write of r9 on the same edge -> pend stays 1.
- reset pulsed for one cycle mid-RUN with r3=0xA5A5A5A5 and r9 pending -> ready drops, r3 reads 0 and pend clears; ready returns DEPTH edges later.
- NREAD=3, NWRITE=1, WIDTH=16, DEPTH=8 -> ready after 8 edges; three simultaneous reads of distinct registers return the correct 16-bit values.
